instr_dispatch: RTL and testbench
=================================

# instr_dispatch

Front-end sequencer directly upstream of the microcode unit. It fetches one instruction word at a time from instruction memory and extracts the 6-bit opcode. It then fires a one-cycle start-of-segment pulse into the microcode unit and waits for its end-of-segment flag before advancing the PC. It also detects the all-ones halt opcode, flags microcode hangs with a watchdog, and counts retired instructions.

## Interface
- `ADDR_WIDTH`, 32, byte address width of the PC and instruction memory
- `RESET_PC`, 0, PC value loaded on reset
- `WDOG_CYCLES`, 1024, maximum EXEC cycles before a fault; 0 disables the watchdog
- `clk  in  1  system clock; one clock domain`
- `rst  in  1  reset; asynchronous, active-high`
- `imem_req  out  1  fetch request; held until ack`
- `imem_addr  out  ADDR_WIDTH  fetch address, equal to the current PC`
- `imem_ack  in  1  read data valid this cycle`
- `imem_rdata  in  32  instruction word`
- `instr  out  32  latched instruction; field source for the datapath`
- `opcode  out  6  instr[31:26]; drives the microcode opcode input`
- `sos  out  1  start-of-segment pulse to the microcode unit`
- `eos  in  1  end-of-segment flag from the microcode unit`
- `pc_load  in  1  branch/jump taken; valid only during EXEC`
- `pc_load_addr  in  ADDR_WIDTH  branch target`
- `pc  out  ADDR_WIDTH  current PC`
- `halted  out  1  halt opcode reached; sticky until rst`
- `fault  out  1  watchdog expired; sticky until rst`
- `retired  out  32  count of completed instructions; wraps modulo 2^32`

## Operation
- States: FETCH, DECODE, ISSUE, EXEC, HALT, FAULT.
- Reset values:
  - state = FETCH, pc = RESET_PC.
  - instr = 0, opcode = 0.
  - imem_req, sos, halted, fault = 0.
  - retired = 0, pend_load = 0.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - On imem_ack: latch imem_rdata into instr, go to DECODE.
- DECODE:
  - opcode == 6'h3F: go to HALT. sos is not pulsed and retired is unchanged.
  - Otherwise go to ISSUE.
- ISSUE:
  - sos = 1 for exactly this cycle.
  - Clear the watchdog counter and pend_load.
  - Go to EXEC.
- EXEC:
  - The watchdog counter increments every cycle.
  - pc_load = 1 sets pend_load and captures pc_load_addr. The last assertion wins.
  - On eos = 1:
    - pc = pend_load ? captured address : pc + 4, with ADDR_WIDTH wrap.
    - If pc_load and eos are high in the same cycle, the current pc_load_addr is used.
    - retired += 1.
    - Go to FETCH.
  - When the counter reaches WDOG_CYCLES with eos = 0: go to FAULT with pc unchanged.
- HALT: halted = 1, no requests. Exit only through rst.
- FAULT: fault = 1, no requests. Exit only through rst.
- Signals outside their valid window:
  - eos is ignored outside EXEC. It stays high between segments, so it is never sampled in FETCH, DECODE or ISSUE.
  - pc_load outside EXEC is ignored.
  - imem_ack outside FETCH is ignored.
- opcode and instr are stable from DECODE until the next imem_ack.
- rst mid-fetch or mid-EXEC: the outstanding request is dropped, sos is not re-issued, and the block returns to the reset values immediately.

## Timing
- Minimum instruction period is 4 cycles: FETCH with ack in the same cycle, DECODE, ISSUE, and 1 EXEC cycle.
- imem_addr and imem_req are registered outputs and change only on a state change.
- sos is a registered output, high for exactly 1 cycle, and never high in two consecutive cycles.
- opcode is valid no later than the cycle sos rises, since the microcode unit indexes its segment table on sos.
- The PC update and the FETCH request appear in the cycle after eos is sampled.
- halted and fault assert in the cycle after the DECODE or EXEC decision.

## Structure
- Shared package `ctrino_pkg`:
  - state enum `dispatch_state_t`.
  - `OPCODE_HALT = 6'h3F`.
  - `OPCODE_MSB = 31`, `OPCODE_LSB = 26`.
  - `INSTR_BYTES = 4`.
- One natural sub-module, `dispatch_wdog`: a loadable down-counter with an expiry flag, parameterised by WDOG_CYCLES.
- All other logic stays in a single FSM with a registered output block.

## Test plan
- Sequential run:
  - Stimulus: RESET_PC = 0; words 0x00000000 at 0x0 and 0x04000000 at 0x4; imem acks with 1-cycle latency; eos 2 cycles after each sos.
  - Required: fetches at 0x0 then 0x4; opcodes 0 then 1; one sos per instruction; retired = 2; pc = 0x8.
- Branch:
  - Stimulus: pc_load = 1 with pc_load_addr = 0x40 in the first EXEC cycle; eos one cycle later.
  - Required: next imem_addr = 0x40; retired increments by 1.
- Halt:
  - Stimulus: fetched word 0xFC000000.
  - Required: opcode = 0x3F; sos never pulses; halted = 1 from the next cycle; imem_req stays 0; retired unchanged.
- Watchdog:
  - Stimulus: WDOG_CYCLES = 8; eos held low after sos.
  - Required: fault = 1 after 8 EXEC cycles; pc unchanged; no further imem_req.
- Stale eos:
  - Stimulus: eos held high continuously.
  - Required: each instruction still spends exactly one EXEC cycle; sos pulses once per instruction; no double retire.
- Reset mid-EXEC:
  - Stimulus: assert rst asynchronously during EXEC.
  - Required: all outputs return to reset values immediately; after release, the first fetch is at RESET_PC.

Source files
------------

// File: rtl/ctrino_pkg.sv
// Shared definitions for the instruction front-end: FSM state encoding,
// opcode field position and the halt opcode.
package ctrino_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        ISSUE  = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4,
        FAULT  = 3'd5
    } dispatch_state_t;

    localparam logic [5:0] OPCODE_HALT = 6'h3F;
    localparam int         OPCODE_MSB  = 31;
    localparam int         OPCODE_LSB  = 26;
    localparam int         INSTR_BYTES = 4;

    // Opcode field of an instruction word
    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_dispatch_if.sv
// Bundle of the instruction-memory bus, microcode handshake and status
// signals of the dispatcher. master = dispatcher side, slave = environment.
interface instr_dispatch_if #(
    parameter int ADDR_WIDTH = 32
) ();
    // instruction memory
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [31:0]           imem_rdata;
    // microcode handshake and datapath fields
    logic [31:0]           instr;
    logic [5:0]            opcode;
    logic                  sos;
    logic                  eos;
    logic                  pc_load;
    logic [ADDR_WIDTH-1:0] pc_load_addr;
    // status
    logic [ADDR_WIDTH-1:0] pc;
    logic                  halted;
    logic                  fault;
    logic [31:0]           retired;

    modport master (
        output imem_req, imem_addr, instr, opcode, sos, pc, halted, fault, retired,
        input  imem_ack, imem_rdata, eos, pc_load, pc_load_addr
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, sos, pc, halted, fault, retired,
        output imem_ack, imem_rdata, eos, pc_load, pc_load_addr
    );
endinterface

// File: rtl/instr_dispatch_wdog.sv
// Watchdog for the EXEC phase: loadable down-counter that flags the cycle in
// which the WDOG_CYCLES-th consecutive run cycle is reached. WDOG_CYCLES = 0
// disables the flag entirely.
module dispatch_wdog #(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic run_i,
    output logic expired_o
);
    localparam int                CNT_W    = (WDOG_CYCLES == 0) ? 1 : $clog2(WDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(WDOG_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on segment start, count down while the segment runs
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter holds 1 during the last allowed run cycle
    generate
        if (WDOG_CYCLES == 0) begin : g_disabled
            assign expired_o = 1'b0;
        end else begin : g_enabled
            assign expired_o = run_i && (cnt_q == CNT_W'(1));
        end
    endgenerate

endmodule

// File: rtl/instr_dispatch.sv
// Instruction front-end sequencer: fetch, decode the opcode, start a
// microcode segment and wait for its end, then advance or branch the PC.
module instr_dispatch
    import ctrino_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    WDOG_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    instr_dispatch_if.master  bus
);

    dispatch_state_t        state_q;
    dispatch_state_t        state_d;

    logic                   imem_req_q;
    logic                   sos_q;
    logic                   halted_q;
    logic                   fault_q;
    logic [31:0]            instr_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [31:0]            retired_q;
    logic                   pend_load_q;
    logic [ADDR_WIDTH-1:0]  pend_addr_q;
    logic                   wdog_expired;

    // Segment watchdog: armed in ISSUE, runs through EXEC
    dispatch_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .load_i    (state_q == ISSUE),
        .run_i     (state_q == EXEC),
        .expired_o (wdog_expired)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; eos wins over a same-cycle watchdog expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (bus.imem_ack) state_d = DECODE;
            DECODE:  state_d = (opcode_of(instr_q) == OPCODE_HALT) ? HALT : ISSUE;
            ISSUE:   state_d = EXEC;
            EXEC: begin
                if (bus.eos) begin
                    state_d = FETCH;
                end else if (wdog_expired) begin
                    state_d = FAULT;
                end
            end
            HALT:    state_d = HALT;
            FAULT:   state_d = FAULT;
            default: state_d = FETCH;
        endcase
    end

    // Registered outputs and datapath: PC, pending branch, instruction latch, retire count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req_q  <= 1'b0;
            sos_q       <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            instr_q     <= '0;
            pc_q        <= RESET_PC;
            retired_q   <= '0;
            pend_load_q <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            imem_req_q <= (state_d == FETCH);
            sos_q      <= (state_d == ISSUE);
            halted_q   <= (state_d == HALT);
            fault_q    <= (state_d == FAULT);

            if ((state_q == FETCH) && bus.imem_ack) begin
                instr_q <= bus.imem_rdata;
            end

            if (state_q == ISSUE) begin
                pend_load_q <= 1'b0;
            end

            if (state_q == EXEC) begin
                if (bus.pc_load) begin
                    pend_load_q <= 1'b1;
                    pend_addr_q <= bus.pc_load_addr;
                end
                if (bus.eos) begin
                    // A branch arriving together with eos still takes effect
                    if (bus.pc_load) begin
                        pc_q <= bus.pc_load_addr;
                    end else if (pend_load_q) begin
                        pc_q <= pend_addr_q;
                    end else begin
                        pc_q <= pc_q + ADDR_WIDTH'(INSTR_BYTES);
                    end
                    retired_q <= retired_q + 32'd1;
                end
            end
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.instr     = instr_q;
    assign bus.opcode    = opcode_of(instr_q);
    assign bus.sos       = sos_q;
    assign bus.pc        = pc_q;
    assign bus.halted    = halted_q;
    assign bus.fault     = fault_q;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Bench for instr_dispatch: randomized instruction stream against a
// transaction-level model of PC, retire count and sticky status flags.
module tb_instr_dispatch;

    localparam int WDOG = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    instr_dispatch_if #(.ADDR_WIDTH(32)) bus ();

    instr_dispatch #(
        .ADDR_WIDTH  (32),
        .RESET_PC    (32'h0),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] model_pc;
    logic [31:0] model_retired;
    logic [31:0] mem [logic [31:0]];

    // Instruction memory contents, filled lazily with non-halt words
    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        logic [31:0] w;
        if (!mem.exists(a)) begin
            w = $urandom;
            if (w[31:26] == 6'h3F) w[26] = 1'b0;
            mem[a] = w;
        end
        return mem[a];
    endfunction

    task automatic apply_reset();
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = '0;
        bus.eos          = 1'b0;
        bus.pc_load      = 1'b0;
        bus.pc_load_addr = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_pc      = 32'h0;
        model_retired = 32'h0;
    endtask

    // One instruction end to end; exec_cycles = 0 means eos never comes
    task automatic do_instr(input int ack_lat, input int exec_cycles, input bit stale,
                            input bit noise, input logic [7:0] load_mask,
                            input bit rand_addr, input logic [31:0] load_base);
        logic [31:0] word, la, tgt;
        bit got, done;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.imem_req === 1'b1) begin
                got = 1'b1;
            end else begin
                bus.eos = stale;
                bus.pc_load = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.pc_load_addr = $urandom;
                @(negedge clk);
            end
        end
        n_cmp++;
        if (!got) begin
            n_mis++;
            $display("FAIL req_timeout: imem_req=%b after 20 cycles, required 1", bus.imem_req);
            return;
        end
        bus.pc_load = 1'b0;
        word = fetch_word(model_pc);
        n_cmp++;
        if (bus.imem_addr !== model_pc) begin
            n_mis++;
            $display("FAIL fetch_addr: got %h required %h", bus.imem_addr, model_pc);
        end
        for (int l = 0; l < ack_lat; l++) begin
            bus.imem_ack = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== model_pc) begin
                n_mis++;
                $display("FAIL req_hold: req=%b addr=%h required 1/%h", bus.imem_req, bus.imem_addr, model_pc);
            end
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = word;
        @(negedge clk);
        // DECODE
        bus.imem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.imem_rdata = $urandom;
        bus.pc_load = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        n_cmp++;
        if (bus.opcode !== word[31:26] || bus.instr !== word || bus.imem_req !== 1'b0 || bus.sos !== 1'b0) begin
            n_mis++;
            $display("FAIL decode: opcode=%h instr=%h req=%b sos=%b required %h/%h/0/0",
                     bus.opcode, bus.instr, bus.imem_req, bus.sos, word[31:26], word);
        end
        if (word[31:26] == 6'h3F) begin
            @(negedge clk);
            bus.imem_ack = 1'b0;
            bus.pc_load = 1'b0;
            n_cmp++;
            if (bus.halted !== 1'b1 || bus.sos !== 1'b0 || bus.imem_req !== 1'b0 || bus.retired !== model_retired) begin
                n_mis++;
                $display("FAIL halt_enter: halted=%b sos=%b req=%b retired=%0d required 1/0/0/%0d",
                         bus.halted, bus.sos, bus.imem_req, bus.retired, model_retired);
            end
            return;
        end
        @(negedge clk);
        // ISSUE
        bus.pc_load = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.pc_load_addr = $urandom;
        n_cmp++;
        if (bus.sos !== 1'b1 || bus.opcode !== word[31:26]) begin
            n_mis++;
            $display("FAIL issue: sos=%b opcode=%h required 1/%h", bus.sos, bus.opcode, word[31:26]);
        end
        done = 1'b0;
        tgt = model_pc + 32'd4;
        for (int k = 1; k <= WDOG && !done; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.sos !== 1'b0 || bus.fault !== 1'b0 || bus.imem_req !== 1'b0) begin
                n_mis++;
                $display("FAIL exec%0d: sos=%b fault=%b req=%b required 0/0/0", k, bus.sos, bus.fault, bus.imem_req);
            end
            la = rand_addr ? ($urandom & 32'hFFFF_FFFC) : load_base;
            bus.pc_load = load_mask[k-1];
            bus.pc_load_addr = la;
            if (load_mask[k-1]) tgt = la;
            bus.eos = stale || (k == exec_cycles);
            bus.imem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.imem_rdata = $urandom;
            if (stale || (k == exec_cycles)) done = 1'b1;
        end
        @(negedge clk);
        bus.pc_load = 1'b0;
        bus.eos = stale;
        bus.imem_ack = 1'b0;
        if (done) begin
            model_pc = tgt;
            model_retired = model_retired + 32'd1;
            n_cmp++;
            if (bus.imem_req !== 1'b1 || bus.pc !== model_pc || bus.imem_addr !== model_pc ||
                bus.retired !== model_retired || bus.sos !== 1'b0 || bus.instr !== word) begin
                n_mis++;
                $display("FAIL retire: req=%b pc=%h addr=%h retired=%0d sos=%b instr=%h required 1/%h/%h/%0d/0/%h",
                         bus.imem_req, bus.pc, bus.imem_addr, bus.retired, bus.sos, bus.instr,
                         model_pc, model_pc, model_retired, word);
            end
        end else begin
            n_cmp++;
            if (bus.fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.pc !== model_pc || bus.retired !== model_retired) begin
                n_mis++;
                $display("FAIL wdog_fault: fault=%b req=%b pc=%h retired=%0d required 1/0/%h/%0d",
                         bus.fault, bus.imem_req, bus.pc, bus.retired, model_pc, model_retired);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.imem_req !== 1'b0 || bus.sos !== 1'b0 || bus.halted !== 1'b0 || bus.fault !== 1'b0 ||
            bus.pc !== 32'h0 || bus.instr !== 32'h0 || bus.opcode !== 6'h0 || bus.retired !== 32'h0) begin
            n_mis++;
            $display("FAIL reset_values: req=%b sos=%b halted=%b fault=%b pc=%h instr=%h retired=%0d required all zero",
                     bus.imem_req, bus.sos, bus.halted, bus.fault, bus.pc, bus.instr, bus.retired);
        end
        rst = 1'b0;
        $display("reset: checked reset values");
    endtask

    task automatic test_sequential();
        mem[32'h0] = 32'h0000_0000;
        mem[32'h4] = 32'h0400_0000;
        do_instr(1, 2, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        do_instr(1, 2, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        n_cmp++;
        if (bus.retired !== 32'd2 || bus.pc !== 32'h8) begin
            n_mis++;
            $display("FAIL sequential: retired=%0d pc=%h required 2/00000008", bus.retired, bus.pc);
        end
        $display("sequential: retired=%0d pc=%h", bus.retired, bus.pc);
    endtask

    task automatic test_branch();
        do_instr(1, 2, 1'b0, 1'b0, 8'h01, 1'b0, 32'h40);
        n_cmp++;
        if (bus.imem_addr !== 32'h40 || bus.retired !== 32'd3) begin
            n_mis++;
            $display("FAIL branch: addr=%h retired=%0d required 00000040/3", bus.imem_addr, bus.retired);
        end
        $display("branch: addr=%h retired=%0d", bus.imem_addr, bus.retired);
    endtask

    task automatic test_pc_wrap();
        do_instr(0, 1, 1'b0, 1'b0, 8'h01, 1'b0, 32'hFFFF_FFFC);
        do_instr(0, 1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        n_cmp++;
        if (bus.pc !== 32'h0) begin
            n_mis++;
            $display("FAIL pc_wrap: pc=%h required 00000000", bus.pc);
        end
        $display("pc_wrap: pc=%h", bus.pc);
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            do_instr($urandom_range(0, 3), $urandom_range(1, WDOG), 1'b0, 1'b1,
                     8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)), 1'b1, 32'h0);
            $display("random %0d: pc=%h retired=%0d", t, bus.pc, bus.retired);
        end
    endtask

    task automatic test_stale_eos();
        for (int t = 0; t < 4; t++) begin
            do_instr($urandom_range(0, 2), 1, 1'b1, 1'b1, 8'h00, 1'b1, 32'h0);
            $display("stale_eos %0d: pc=%h retired=%0d", t, bus.pc, bus.retired);
        end
        bus.eos = 1'b0;
    endtask

    task automatic test_watchdog();
        logic [31:0] pc_hold;
        do_instr(0, WDOG, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        $display("wdog_boundary: eos in last allowed cycle, fault=%b", bus.fault);
        pc_hold = model_pc;
        do_instr(0, 0, 1'b0, 1'b1, 8'hFF, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.sos !== 1'b0 || bus.pc !== pc_hold) begin
                n_mis++;
                $display("FAIL fault_sticky: fault=%b req=%b sos=%b pc=%h required 1/0/0/%h",
                         bus.fault, bus.imem_req, bus.sos, bus.pc, pc_hold);
            end
        end
        $display("watchdog: fault=%b pc=%h", bus.fault, bus.pc);
    endtask

    task automatic test_halt();
        logic [31:0] hpc;
        do_instr(0, 1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        do_instr(0, 1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        hpc = model_pc;
        mem[hpc] = 32'hFC00_0000;
        do_instr(1, 1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.sos !== 1'b0 ||
                bus.opcode !== 6'h3F || bus.retired !== model_retired) begin
                n_mis++;
                $display("FAIL halt_hold: halted=%b req=%b sos=%b opcode=%h retired=%0d required 1/0/0/3f/%0d",
                         bus.halted, bus.imem_req, bus.sos, bus.opcode, bus.retired, model_retired);
            end
        end
        mem.delete(hpc);
        $display("halt: halted=%b retired=%0d", bus.halted, bus.retired);
    endtask

    task automatic test_reset_mid_exec();
        bit got;
        do_instr(0, 1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.imem_req === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hA5A5_1234;
        @(negedge clk);               // DECODE
        bus.imem_ack = 1'b0;
        @(negedge clk);               // ISSUE
        @(negedge clk);               // EXEC 1
        bus.pc_load = 1'b1;
        bus.pc_load_addr = 32'h80;
        @(negedge clk);               // EXEC 2
        bus.pc_load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.imem_req !== 1'b0 || bus.sos !== 1'b0 || bus.halted !== 1'b0 || bus.fault !== 1'b0 ||
            bus.pc !== 32'h0 || bus.instr !== 32'h0 || bus.opcode !== 6'h0 || bus.retired !== 32'h0) begin
            n_mis++;
            $display("FAIL async_reset: req=%b sos=%b pc=%h instr=%h retired=%0d required all zero",
                     bus.imem_req, bus.sos, bus.pc, bus.instr, bus.retired);
        end
        @(negedge clk);
        rst = 1'b0;
        model_pc = 32'h0;
        model_retired = 32'h0;
        do_instr(0, 2, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        $display("reset_mid_exec: pc=%h retired=%0d", bus.pc, bus.retired);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_pc_wrap();
        test_random();
        test_stale_eos();
        test_watchdog();
        apply_reset();
        test_halt();
        apply_reset();
        test_reset_mid_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
